imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
UART-side writer for the instruction memory's programming port: receives a framed program image on a serial RX line and drives the memory's WE/A/WD write interface. It assembles little-endian bytes into 32-bit words, writes them to consecutive word addresses starting at 0, and verifies a trailing XOR checksum. BUSY/DONE/ERR hold the core in reset during a load and release it afterwards.

Parameters:
CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); must be at least 4.
MAX_WORDS, 64, instruction memory depth in words; a larger word count is rejected.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
RX  input  1  UART receive line, idle high, asynchronous to CLK
IMEM_WE  output  1  one-cycle write strobe to instruction memory
IMEM_A  output  32  byte address of the write (word-aligned)
IMEM_WD  output  32  write data word
BUSY  output  1  load in progress (SYNC_BYTE seen, frame not finished)
DONE  output  1  last frame loaded with a good checksum (level)
ERR  output  1  last frame failed (level)

Behaviour:
- Reset: one clock, CLK; asynchronous active-low reset RST_N. All state is cleared immediately while RST_N is low.
- Reset values: IMEM_WE=0, IMEM_A=0, IMEM_WD=0, BUSY=0, DONE=0, ERR=0; UART in RX_IDLE; loader in L_IDLE.
- RX synchronizer: two flops, reset value 1. All logic uses only the synchronized value.
- UART receiver, 8N1, LSB first. States:
  - RX_IDLE -> RX_START on a synchronized low.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then resample. Low -> RX_DATA; high -> glitch, return to RX_IDLE.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits.
  - RX_STOP: sample after CLKS_PER_BIT. High -> one-cycle byte_valid with the byte. Low -> one-cycle frame_err, no byte_valid.
  - Return to RX_IDLE after the stop sample.
- Frame format (little-endian): SYNC_BYTE, CNT_LO, CNT_HI, then N words of 4 bytes each, then CSUM. CSUM is the XOR of every byte after SYNC_BYTE.
- Loader FSM:
  - L_IDLE: non-SYNC bytes and frame_err are ignored. On SYNC_BYTE: clear DONE/ERR, set BUSY, reset checksum, word index and byte index -> L_CNT0.
  - L_CNT0 -> L_CNT1 -> range check. N > MAX_WORDS -> L_ERR. N == 0 -> L_CSUM. Otherwise -> L_DATA.
  - L_DATA: byte k fills WD[8k+7:8k]. On the 4th byte, IMEM_WE=1 for exactly one cycle (the cycle after that byte_valid), with IMEM_A = {word_idx, 2'b00} and IMEM_WD = the assembled word; word_idx increments. After word N-1 -> L_CSUM.
  - L_CSUM: received byte == running XOR -> DONE=1; otherwise ERR=1. BUSY=0, -> L_IDLE.
  - L_ERR: ERR=1, BUSY=0, -> L_IDLE.
- Words already written are not rolled back on error.
- frame_err in any state other than L_IDLE -> L_ERR.
- SYNC_BYTE inside the count, data or CSUM fields is treated as data, not a restart.
- IMEM_A and IMEM_WD hold their last values when IMEM_WE=0. IMEM_WE is never asserted outside L_DATA.
- DONE and ERR are never high together. Both hold until the next SYNC_BYTE or reset.
- Reset mid-frame aborts the load; the partial image stays in memory.

Decomposition:
- Shared package: SYNC_BYTE constant, receiver state enum, loader state enum, and a word-count width derived as clog2(MAX_WORDS+1) rounded up to 16.
- One sub-module: uart_rx_byte (synchronizer, bit timing, byte_valid/frame_err). The loader FSM stays in the top module.

Test Plan (CLKS_PER_BIT=8; all bytes sent at exact bit rate):
- Good frame: A5 02 00 93 00 10 00 37 03 00 80 35 -> two IMEM_WE pulses, A=0 WD=32'h00100093 then A=4 WD=32'h80000337. DONE=1, ERR=0, BUSY=0 after the CSUM byte.
- Bad checksum: same frame with last byte 36 -> both writes still occur, ERR=1, DONE=0.
- Oversize count: A5 41 00 -> no IMEM_WE, ERR=1 right after CNT_HI. Follow with the good frame -> ERR clears at A5, DONE=1.
- Noise and framing: garbage bytes 00 FF 12 before A5, plus a 2-cycle RX low glitch -> ignored, with no BUSY and no writes. A stop bit forced low during data byte 2 -> ERR=1, no partial write.
- Zero words: A5 00 00 00 -> DONE=1, no IMEM_WE.
- RST_N pulsed low mid-data -> all outputs return to 0 immediately. The next full frame loads correctly from address 0.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
package imem_uart_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned MAX_WORDS_DEF = 64;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {L_IDLE, L_CNT0, L_CNT1, L_DATA, L_CSUM, L_ERR} ld_state_t;

  // Word-count register width: bits needed for 0..max_words, rounded up to 16.
  function automatic int unsigned cnt_width(input int unsigned max_words);
    int unsigned w;
    w = $clog2(max_words + 1);
    return ((w + 15) / 16) * 16;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port plus load status, driven by the loader.
interface imem_uart_loader_if;
  logic        imem_we;
  logic [31:0] imem_a;
  logic [31:0] imem_wd;
  logic        busy;
  logic        done;
  logic        err;

  modport master (output imem_we, imem_a, imem_wd, busy, done, err);
  modport slave  (input  imem_we, imem_a, imem_wd, busy, done, err);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop RX synchronizer, mid-bit sampling, registered
// one-cycle byte_valid / frame_err strobes.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic          sync1, rx_s;
  rx_state_t     state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          valid_n, ferr_n;

  // Idle-high synchronizer for the asynchronous line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      tcnt       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt + TW'(1);
    bit_n   = bit_idx;
    sh_n    = shreg;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      RX_IDLE: begin
        tcnt_n = '0;
        if (!rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (tcnt == HALF_M1) begin
          tcnt_n  = '0;
          bit_n   = '0;
          state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tcnt == FULL_M1) begin
          tcnt_n = '0;
          sh_n   = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (tcnt == FULL_M1) begin
          tcnt_n  = '0;
          state_n = RX_IDLE;
          valid_n = rx_s;
          ferr_n  = ~rx_s;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/imem_uart_loader.sv
// Frame loader: parses SYNC / count / words / checksum from the UART and writes
// consecutive words into instruction memory, reporting BUSY / DONE / ERR.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_WORDS    = MAX_WORDS_DEF,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RX,
  imem_uart_loader_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(MAX_WORDS);

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rx        (RX),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  ld_state_t          state, state_n;
  logic               busy, busy_n, done, done_n, err, err_n, we, we_n;
  logic [31:0]        a, a_n, wd, wd_n, asm_r, asm_n;
  logic [7:0]         csum, csum_n;
  logic [CNT_W-1:0]   word_idx, word_n, count, count_n;
  logic [1:0]         byte_idx, bidx_n;
  logic [15:0]        n_words;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= L_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      we       <= 1'b0;
      a        <= '0;
      wd       <= '0;
      asm_r    <= '0;
      csum     <= '0;
      word_idx <= '0;
      count    <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      we       <= we_n;
      a        <= a_n;
      wd       <= wd_n;
      asm_r    <= asm_n;
      csum     <= csum_n;
      word_idx <= word_n;
      count    <= count_n;
      byte_idx <= bidx_n;
    end
  end

  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = done;
    err_n   = err;
    we_n    = 1'b0;
    a_n     = a;
    wd_n    = wd;
    asm_n   = asm_r;
    csum_n  = csum;
    word_n  = word_idx;
    count_n = count;
    bidx_n  = byte_idx;
    n_words = {rx_byte, count[7:0]};
    case (state)
      L_IDLE: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          done_n  = 1'b0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          csum_n  = '0;
          word_n  = '0;
          bidx_n  = '0;
          state_n = L_CNT0;
        end
      end
      L_CNT0: begin
        if (byte_valid) begin
          count_n = CNT_W'(rx_byte);
          csum_n  = csum ^ rx_byte;
          state_n = L_CNT1;
        end
      end
      L_CNT1: begin
        if (byte_valid) begin
          count_n = CNT_W'(n_words);
          csum_n  = csum ^ rx_byte;
          if (32'(n_words) > 32'(MAX_WORDS)) state_n = L_ERR;
          else if (n_words == 16'd0)          state_n = L_CSUM;
          else                                state_n = L_DATA;
        end
      end
      L_DATA: begin
        if (byte_valid) begin
          csum_n = csum ^ rx_byte;
          asm_n[{byte_idx, 3'b000} +: 8] = rx_byte;
          bidx_n = byte_idx + 2'd1;
          // Fourth byte completes the little-endian word
          if (byte_idx == 2'd3) begin
            we_n   = 1'b1;
            a_n    = 32'({word_idx, 2'b00});
            wd_n   = {rx_byte, asm_r[23:0]};
            word_n = word_idx + CNT_W'(1);
            if (word_idx + CNT_W'(1) == count) state_n = L_CSUM;
          end
        end
      end
      L_CSUM: begin
        if (byte_valid) begin
          busy_n  = 1'b0;
          state_n = L_IDLE;
          if (rx_byte == csum) done_n = 1'b1;
          else                 err_n  = 1'b1;
        end
      end
      L_ERR: begin
        err_n   = 1'b1;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = L_IDLE;
      end
      default: state_n = L_IDLE;
    endcase
    // A broken stop bit anywhere inside a frame aborts it
    if (frame_err && state != L_IDLE && state != L_ERR) begin
      we_n    = 1'b0;
      state_n = L_ERR;
    end
  end

  assign bus.imem_we = we;
  assign bus.imem_a  = a;
  assign bus.imem_wd = wd;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: frame table plus hand-written noise, stop-bit and
// reset sequences; expected memory writes are scoreboarded from the frame bytes.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int unsigned CPB = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] wd;
  } wr_t;

  typedef struct {
    logic [7:0] b [12];
    int         len;
    logic       exp_done;
    logic       exp_err;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  int   checks = 0;
  int   passed = 0;
  wr_t  exp_q[$];
  frame_t tbl [5];

  always #5 clk = ~clk;

  imem_uart_loader_if bus ();

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (64),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .RX   (rx),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got a=%h wd=%h expected no write", bus.imem_a, bus.imem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("imem_a", bus.imem_a, e.a);
        chk("imem_wd", bus.imem_wd, e.wd);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (bad_stop) begin
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (CPB - 5) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Reference model: writes implied by a frame's count and complete data words
  task automatic push_model(input int idx);
    int n;
    wr_t e;
    if (tbl[idx].len >= 3) begin
      n = int'({tbl[idx].b[2], tbl[idx].b[1]});
      if (n > 0 && n <= 64) begin
        for (int w = 0; w < n; w++) begin
          if (3 + 4 * w + 3 < tbl[idx].len) begin
            e.a  = 32'(4 * w);
            e.wd = {tbl[idx].b[6 + 4 * w], tbl[idx].b[5 + 4 * w],
                    tbl[idx].b[4 + 4 * w], tbl[idx].b[3 + 4 * w]};
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic run_frame(input int idx);
    push_model(idx);
    send_byte(tbl[idx].b[0], 1'b0);
    repeat (4) @(negedge clk);
    chk($sformatf("f%0d_busy_after_sync", idx), 32'(bus.busy), 32'd1);
    chk($sformatf("f%0d_done_clr", idx), 32'(bus.done), 32'd0);
    chk($sformatf("f%0d_err_clr", idx), 32'(bus.err), 32'd0);
    for (int j = 1; j < tbl[idx].len; j++) send_byte(tbl[idx].b[j], 1'b0);
    repeat (12) @(negedge clk);
    chk($sformatf("f%0d_done", idx), 32'(bus.done), 32'(tbl[idx].exp_done));
    chk($sformatf("f%0d_err", idx), 32'(bus.err), 32'(tbl[idx].exp_err));
    chk($sformatf("f%0d_busy_end", idx), 32'(bus.busy), 32'd0);
    chk($sformatf("f%0d_writes_left", idx), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tbl[0].b = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                 8'h37, 8'h03, 8'h00, 8'h80, 8'h35};
    tbl[0].len = 12; tbl[0].exp_done = 1'b1; tbl[0].exp_err = 1'b0;
    tbl[1] = tbl[0];
    tbl[1].b[11] = 8'h36; tbl[1].exp_done = 1'b0; tbl[1].exp_err = 1'b1;
    tbl[2].b = '{8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].len = 3; tbl[2].exp_done = 1'b0; tbl[2].exp_err = 1'b1;
    tbl[3] = tbl[0];
    tbl[4].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].len = 4; tbl[4].exp_done = 1'b1; tbl[4].exp_err = 1'b0;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_a", bus.imem_a, 32'd0);
    chk("rst_wd", bus.imem_wd, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Garbage bytes and a short low glitch must not start a load
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    chk("noise_busy", 32'(bus.busy), 32'd0);
    chk("noise_done", 32'(bus.done), 32'd0);
    chk("noise_err", 32'(bus.err), 32'd0);

    for (int i = 0; i < 5; i++) run_frame(i);

    // Low stop bit on the second data byte: abort without a partial write
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (12) @(negedge clk);
    chk("ferr_err", 32'(bus.err), 32'd1);
    chk("ferr_done", 32'(bus.done), 32'd0);
    chk("ferr_busy", 32'(bus.busy), 32'd0);
    chk("ferr_writes_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a data byte clears everything at once
    run_frame(0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
    chk("mid_rst_a", bus.imem_a, 32'd0);
    chk("mid_rst_wd", bus.imem_wd, 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_frame(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
